// File: rtl/uart_frame_scheduler_if.sv
// Handshake bundle between the frame scheduler, its two requesters and the shared uart_tx.
interface uart_frame_scheduler_if;
  logic        req0;
  logic [15:0] data0;
  logic        ack0;
  logic        req1;
  logic [15:0] data1;
  logic        ack1;
  logic        tx_transmit;
  logic [7:0]  tx_data;
  logic        tx_active;
  logic        tx_done;
  logic        busy;
  logic        grant;

  modport master (
    input  req0, data0, req1, data1, tx_active, tx_done,
    output ack0, ack1, tx_transmit, tx_data, busy, grant
  );

  modport slave (
    output req0, data0, req1, data1, tx_active, tx_done,
    input  ack0, ack1, tx_transmit, tx_data, busy, grant
  );
endinterface

// File: rtl/uart_frame_scheduler.sv
// Round-robin sharing of one uart_tx between two requesters; sends MAGIC, payload and a
// serially computed CRC16 as an 8-byte frame, then holds an idle gap before the next grant.
module uart_frame_scheduler #(
  parameter logic [31:0] MAGIC      = 32'hDABBAD00,
  parameter logic [15:0] CRC_INIT   = 16'hFFFF,
  parameter int unsigned GAP_CYCLES = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  uart_frame_scheduler_if.master bus
);
  localparam int              GW       = $clog2(GAP_CYCLES + 1);
  localparam logic [GW-1:0]   GAP_LOAD = GW'(GAP_CYCLES);
  localparam logic [15:0]     POLY     = 16'h8005;

  typedef enum logic [2:0] {IDLE, CRC, SEND, WAIT, GAP} state_t;

  state_t        state, state_nx;
  logic [15:0]   payload, crc, crc_step, pick_data;
  logic [47:0]   word;
  logic [5:0]    bit_cnt;
  logic [2:0]    idx;
  logic [GW-1:0] gap_cnt;
  logic          grant_r, rr_next, do_grant, pick, fb;
  logic [7:0]    frame_byte;

  assign do_grant  = (state == IDLE) && (bus.req0 || bus.req1) && !bus.tx_active;
  assign pick      = (bus.req0 && bus.req1) ? rr_next : bus.req1;
  assign pick_data = pick ? bus.data1 : bus.data0;

  // Serial CRC: the message word's MSB is shifted in first.
  assign fb       = crc[15] ^ word[47];
  assign crc_step = {crc[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);

  always_comb begin
    frame_byte = 8'h00;
    case (idx)
      3'd0: frame_byte = MAGIC[31:24];
      3'd1: frame_byte = MAGIC[23:16];
      3'd2: frame_byte = MAGIC[15:8];
      3'd3: frame_byte = MAGIC[7:0];
      3'd4: frame_byte = payload[15:8];
      3'd5: frame_byte = payload[7:0];
      3'd6: frame_byte = crc[15:8];
      default: frame_byte = crc[7:0];
    endcase
  end

  always_comb begin
    state_nx        = state;
    bus.tx_transmit = 1'b0;
    bus.ack0        = 1'b0;
    bus.ack1        = 1'b0;
    case (state)
      IDLE: if (do_grant) state_nx = CRC;
      CRC:  if (bit_cnt == 6'd47) state_nx = SEND;
      SEND: if (!bus.tx_active) begin
        bus.tx_transmit = 1'b1;
        state_nx        = WAIT;
      end
      WAIT: if (bus.tx_done) begin
        if (idx == 3'd7) begin
          bus.ack0 = !grant_r;
          bus.ack1 = grant_r;
          state_nx = GAP;
        end else begin
          state_nx = SEND;
        end
      end
      GAP:  if (gap_cnt <= GW'(1)) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign bus.tx_data = (state == SEND || state == WAIT) ? frame_byte : 8'h00;
  assign bus.busy    = (state != IDLE);
  assign bus.grant   = grant_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      payload <= '0;
      crc     <= '0;
      word    <= '0;
      bit_cnt <= '0;
      idx     <= '0;
      gap_cnt <= '0;
      grant_r <= 1'b0;
      rr_next <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (do_grant) begin
          grant_r <= pick;
          rr_next <= ~pick;
          payload <= pick_data;
          word    <= {pick_data[7:0], pick_data[15:8], MAGIC[7:0],
                      MAGIC[15:8], MAGIC[23:16], MAGIC[31:24]};
          crc     <= CRC_INIT;
          bit_cnt <= '0;
          idx     <= '0;
        end
        CRC: begin
          crc     <= crc_step;
          word    <= {word[46:0], 1'b0};
          bit_cnt <= bit_cnt + 6'd1;
        end
        WAIT: if (bus.tx_done) begin
          if (idx != 3'd7) idx <= idx + 3'd1;
          else             gap_cnt <= GAP_LOAD;
        end
        GAP: if (gap_cnt != '0) gap_cnt <= gap_cnt - GW'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_frame_scheduler.sv
// Scoreboard bench: expected frames and acks are queued at each grant from a spec-level
// model (RR rule, golden CRC16) and a negedge monitor pops and compares.
module tb_uart_frame_scheduler;
  localparam int          GAP   = 256;
  localparam logic [31:0] MAGIC = 32'hDABBAD00;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_frame_scheduler_if bus();

  uart_frame_scheduler #(.MAGIC(MAGIC), .CRC_INIT(16'hFFFF), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  bit stray_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // CRC16 poly 0x8005, seed FFFF, bytes payload lo, payload hi, MAGIC lo..hi, each MSB first.
  function automatic logic [15:0] crc16(input logic [15:0] p);
    logic [7:0]  seq [6];
    logic [15:0] c;
    seq = '{p[7:0], p[15:8], MAGIC[7:0], MAGIC[15:8], MAGIC[23:16], MAGIC[31:24]};
    c = 16'hFFFF;
    for (int i = 0; i < 6; i++)
      for (int b = 7; b >= 0; b--)
        c = (c[15] ^ seq[i][b]) ? ((c << 1) ^ 16'h8005) : (c << 1);
    return c;
  endfunction

  // ---------------- scoreboard / monitor ----------------
  logic [7:0]  exp_b[$];
  int          exp_a[$];
  int          grants[$];
  logic        p_req0, p_req1, p_busy, p_act;
  logic [15:0] p_d0, p_d1;
  int          last_served, cyc, grant_cyc, last_ack, nbytes;
  bit          holding, in_rst;
  logic [7:0]  held;

  initial begin : monitor
    int          id;
    logic [15:0] d, c;
    cyc = 0; last_served = 1; last_ack = -1; nbytes = 0; holding = 0; in_rst = 0;
    p_req0 = 0; p_req1 = 0; p_busy = 0; p_act = 0; p_d0 = 0; p_d1 = 0; grant_cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        if (!in_rst) begin
          chk("rst_tx_transmit", bus.tx_transmit, 0);
          chk("rst_tx_data", bus.tx_data, 0);
          chk("rst_ack0", bus.ack0, 0);
          chk("rst_ack1", bus.ack1, 0);
          chk("rst_busy", bus.busy, 0);
          chk("rst_grant", bus.grant, 0);
        end
        in_rst = 1; exp_b.delete(); exp_a.delete();
        last_served = 1; last_ack = -1; nbytes = 0; holding = 0;
      end else begin
        in_rst = 0;
        if (bus.busy && !p_busy) begin
          chk("grant_with_tx_idle", p_act, 0);
          if (!p_req0 && !p_req1) chk("grant_without_req", 1, 0);
          id = (p_req0 && p_req1) ? (last_served == 0 ? 1 : 0) : (p_req1 ? 1 : 0);
          chk("grant_index", bus.grant, id);
          last_served = id;
          grants.push_back(id);
          d = id ? p_d1 : p_d0;
          c = crc16(d);
          exp_b.push_back(MAGIC[31:24]); exp_b.push_back(MAGIC[23:16]);
          exp_b.push_back(MAGIC[15:8]);  exp_b.push_back(MAGIC[7:0]);
          exp_b.push_back(d[15:8]); exp_b.push_back(d[7:0]);
          exp_b.push_back(c[15:8]); exp_b.push_back(c[7:0]);
          exp_a.push_back(id);
          grant_cyc = cyc - 1;
          nbytes = 0;
        end
        if (holding) chk("tx_data_hold", bus.tx_data, held);
        if (bus.tx_transmit) begin
          chk("tx_while_active", bus.tx_active, 0);
          if (nbytes == 0) begin
            chk("first_byte_latency", cyc - grant_cyc, 49);
            if (last_ack >= 0) chk("gap_respected", (cyc - last_ack) >= GAP, 1);
          end
          if (exp_b.size() == 0) chk("unexpected_byte", 1, 0);
          else chk($sformatf("frame_byte%0d", nbytes), bus.tx_data, exp_b.pop_front());
          held = bus.tx_data; holding = 1; nbytes++;
        end
        if (bus.ack0 || bus.ack1) begin
          chk("ack_onehot", bus.ack0 && bus.ack1, 0);
          if (exp_a.size() == 0) chk("unexpected_ack", 1, 0);
          else chk("ack_index", bus.ack1, exp_a.pop_front());
          chk("bytes_per_frame", nbytes, 8);
          last_ack = cyc;
        end
        if (bus.tx_done) holding = 0;
      end
      p_req0 = bus.req0; p_req1 = bus.req1; p_d0 = bus.data0; p_d1 = bus.data1;
      p_busy = rst ? 1'b0 : bus.busy; p_act = bus.tx_active;
    end
  end

  // ---------------- uart_tx model ----------------
  initial begin : uart
    int rem;
    bit fire;
    rem = 0;
    bus.tx_active = 0; bus.tx_done = 0;
    forever begin
      @(negedge clk);
      fire = bus.tx_transmit;
      @(posedge clk); #1;
      bus.tx_done = 0;
      if (rem > 0) begin
        rem--;
        if (rem == 0) begin bus.tx_done = 1; bus.tx_active = 0; end
      end else if (fire) begin
        bus.tx_active = 1; rem = $urandom_range(2, 10);
      end else if (stray_en && $urandom_range(0, 7) == 0) begin
        bus.tx_done = 1;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_req(input int r, input logic v);
    if (r == 0) bus.req0 = v; else bus.req1 = v;
  endtask

  task automatic set_data(input int r, input logic [15:0] d);
    if (r == 0) bus.data0 = d; else bus.data1 = d;
  endtask

  task automatic wait_ack(input int r, input bit wiggle);
    bit got = 0;
    for (int i = 0; i < 4000 && !got; i++) begin
      @(negedge clk);
      got = (r == 0) ? bus.ack0 : bus.ack1;
      if (!got && wiggle && $urandom_range(0, 7) == 0) begin
        @(posedge clk); #1; set_data(r, 16'($urandom));
      end
    end
    if (!got) chk($sformatf("ack%0d_timeout", r), 0, 1);
  endtask

  task automatic do_frame(input int r, input logic [15:0] d, input bit wiggle);
    @(posedge clk); #1; set_data(r, d); set_req(r, 1);
    wait_ack(r, wiggle);
    @(posedge clk); #1; set_req(r, 0);
  endtask

  task automatic pulse_rst();
    @(posedge clk); #1; rst = 1;
    @(posedge clk); #1; rst = 0;
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int  acks;
    bit  ok;
    bus.req0 = 0; bus.req1 = 0; bus.data0 = 0; bus.data1 = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;

    // single telemetry frame with 1234
    do_frame(0, 16'h1234, 0);

    // simultaneous requests held for four frames: order 0,1,0,1
    pulse_rst();
    grants.delete();
    @(posedge clk); #1;
    bus.data0 = 16'($urandom); bus.data1 = 16'($urandom); bus.req0 = 1; bus.req1 = 1;
    acks = 0;
    for (int i = 0; i < 8000 && acks < 4; i++) begin
      @(negedge clk);
      if (bus.ack0 || bus.ack1) acks++;
    end
    @(posedge clk); #1; bus.req0 = 0; bus.req1 = 0;
    chk("tie_ack_count", acks, 4);
    chk("tie_grant_count", grants.size(), 4);
    for (int k = 0; k < 4 && k < grants.size(); k++)
      chk($sformatf("rr_order%0d", k), grants[k], k % 2);

    // payload change after grant must not reach the frame
    @(posedge clk); #1; bus.data0 = 16'h1234; bus.req0 = 1;
    ok = 0;
    for (int i = 0; i < 2000 && !ok; i++) begin @(negedge clk); ok = bus.busy && bus.tx_transmit == 0 && nbytes == 0 && exp_b.size() == 8; end
    chk("late_payload_grant_seen", ok, 1);
    repeat (2) @(posedge clk);
    #1 bus.data0 = 16'hFFFF;
    wait_ack(0, 0);
    @(posedge clk); #1; bus.req0 = 0;

    // reset during byte 3 while uart busy, request kept high
    @(posedge clk); #1; bus.data0 = 16'($urandom); bus.req0 = 1;
    ok = 0;
    for (int i = 0; i < 3000 && !ok; i++) begin @(negedge clk); ok = (nbytes == 4) && bus.tx_active; end
    chk("reached_byte3", ok, 1);
    pulse_rst();
    wait_ack(0, 0);
    @(posedge clk); #1; bus.req0 = 0;

    // randomized traffic with stray tx_done pulses and payload wiggle
    stray_en = 1;
    fork
      begin
        for (int n = 0; n < 5; n++) begin
          repeat ($urandom_range(0, 300)) @(posedge clk);
          do_frame(0, 16'($urandom), 1);
        end
      end
      begin
        for (int n = 0; n < 5; n++) begin
          repeat ($urandom_range(0, 300)) @(posedge clk);
          do_frame(1, 16'($urandom), 1);
        end
      end
    join
    stray_en = 0;

    repeat (GAP + 100) @(posedge clk);
    chk("leftover_bytes", exp_b.size(), 0);
    chk("leftover_acks", exp_a.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
